// File: rtl/pluse_param_loader_pkg.sv
// Shared definitions for the pulse-generator parameter loader.
//   DEPTH_DEF / LOAD_W_DEF / TIMEOUT_DEF : default buffer depth, strobe width, wait limit
//   DATA_W / ENTRY_W                     : parameter word width and stored entry width
//   entry_t                              : one buffer entry, {choice, data}
//   state_e                              : loader FSM states
package pluse_param_loader_pkg;

  localparam int unsigned DEPTH_DEF   = 8;
  localparam int unsigned LOAD_W_DEF  = 2;
  localparam int unsigned TIMEOUT_DEF = 1000000;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned ENTRY_W     = 17;

  typedef struct packed {
    logic              choice;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_START,
    ST_WAIT_INT
  } state_e;

endpackage

// File: rtl/pluse_param_buf.sv
// Parameter word buffer: DEPTH x ENTRY_W register file, no reset on storage.
//   clk_sys : system clock
//   we      : write enable (commits at the clock edge)
//   waddr   : write entry index
//   wdata   : {choice, data} to store
//   raddr   : read entry index
//   rdata   : asynchronous read of entry[raddr]
module pluse_param_buf
  import pluse_param_loader_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_sys,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_sys) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pluse_param_loader.sv
// Host-side writer for the pulse generator parameter load interface.
// Buffers up to DEPTH words, serialises them as SETUP / STROBE(LOAD_W) / HOLD
// frames onto plusedatain/pluseload/pluseloadchoice, pulses plusestart, then
// waits for a rising edge of pluseinter (or TIMEOUT cycles).
//   clk_sys, pluserst          : clock, synchronous active-low reset
//   host_we/addr/data/choice   : buffer write port (IDLE only)
//   host_count, host_go        : words per run (clamped to DEPTH), start command
//   host_abort                 : return to IDLE from any active state
//   pluseinter                 : completion flag from the pulse generator
//   plusedatain, pluseload,
//   pluseloadchoice, plusestart: registered pulse generator load interface
//   busy, done, err_timeout,
//   err_wr_busy                : registered status (done/err flags sticky)
module pluse_param_loader
  import pluse_param_loader_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned LOAD_W  = LOAD_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk_sys,
  input  logic                     pluserst,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [DATA_W-1:0]        host_data,
  input  logic                     host_choice,
  input  logic [$clog2(DEPTH):0]   host_count,
  input  logic                     host_go,
  input  logic                     host_abort,
  input  logic                     pluseinter,
  output logic [DATA_W-1:0]        plusedatain,
  output logic                     pluseload,
  output logic                     pluseloadchoice,
  output logic                     plusestart,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic                     err_wr_busy
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned NW    = AW + 1;
  localparam int unsigned CMAX  = (TIMEOUT > LOAD_W) ? TIMEOUT : LOAD_W;
  localparam int unsigned CW    = $clog2(CMAX + 1);
  localparam logic [NW-1:0] DEPTH_N     = NW'(DEPTH);
  localparam logic [CW-1:0] STROBE_LAST = CW'(LOAD_W - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [NW-1:0] count_q, count_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          inter_prev_q, inter_prev_d;
  entry_t        word_q, word_d;
  logic          load_q, load_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_to_q, err_to_d;
  logic          err_wr_q, err_wr_d;

  logic   wr_en;
  logic   go_ok;
  logic   inter_rise;
  entry_t wr_word;
  entry_t buf_rdata;
  entry_t rd_word;

  assign wr_en      = host_we && (state_q == ST_IDLE);
  assign go_ok      = host_go && !host_abort && (state_q == ST_IDLE);
  assign inter_rise = pluseinter && !inter_prev_q;
  assign wr_word    = '{choice: host_choice, data: host_data};

  pluse_param_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_sys (clk_sys),
    .we      (wr_en),
    .waddr   (host_addr),
    .wdata   (wr_word),
    .raddr   (idx_d[AW-1:0]),
    .rdata   (buf_rdata)
  );

  // Outputs are registered from the next state, so the word for a SETUP is
  // fetched one cycle early; a write in the go cycle is forwarded so that the
  // first SETUP already sees it.
  assign rd_word = (wr_en && (host_addr == idx_d[AW-1:0])) ? wr_word : buf_rdata;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    cnt_d        = cnt_q;
    done_d       = done_q;
    err_to_d     = err_to_q;
    err_wr_d     = err_wr_q | (host_we && (state_q != ST_IDLE));
    inter_prev_d = pluseinter;

    if ((state_q != ST_IDLE) && host_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (go_ok) begin
            count_d  = (host_count > DEPTH_N) ? DEPTH_N : host_count;
            idx_d    = '0;
            done_d   = 1'b0;
            err_to_d = 1'b0;
            err_wr_d = 1'b0;
            state_d  = (host_count == '0) ? ST_START : ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end
        ST_STROBE: begin
          if (cnt_q == STROBE_LAST) begin
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_HOLD: begin
          idx_d   = idx_q + NW'(1);
          state_d = (idx_d < count_q) ? ST_SETUP : ST_START;
        end
        ST_START: begin
          cnt_d   = '0;
          state_d = ST_WAIT_INT;
        end
        ST_WAIT_INT: begin
          if (inter_rise) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (cnt_q == WAIT_LAST) begin
            err_to_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_d  = (state_d == ST_STROBE);
    start_d = (state_d == ST_START);
    busy_d  = (state_d != ST_IDLE);
    unique case (state_d)
      ST_SETUP:          word_d = rd_word;
      ST_STROBE, ST_HOLD: word_d = word_q;
      default:           word_d = '0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!pluserst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      inter_prev_q <= 1'b0;
      word_q       <= '0;
      load_q       <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_to_q     <= 1'b0;
      err_wr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      inter_prev_q <= inter_prev_d;
      word_q       <= word_d;
      load_q       <= load_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_to_q     <= err_to_d;
      err_wr_q     <= err_wr_d;
    end
  end

  assign plusedatain     = word_q.data;
  assign pluseloadchoice = word_q.choice;
  assign pluseload       = load_q;
  assign plusestart      = start_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_timeout     = err_to_q;
  assign err_wr_busy     = err_wr_q;

endmodule

// File: tb/tb_pluse_param_loader.sv
module tb_pluse_param_loader;

  localparam int DEPTH = 8;
  localparam int L     = 2;
  localparam int TMO   = 50;
  localparam int P     = 2 + L;

  localparam int K_LOAD  = 0;
  localparam int K_START = 1;
  localparam int K_END   = 2;

  localparam int M_INT = 0;
  localparam int M_TO  = 1;
  localparam int M_ABT = 2;
  localparam int M_RST = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [16:0] word;
    logic [16:0] hold;
    int          len;
    logic [2:0]  flags;
  } exp_t;

  logic        clk;
  logic        pluserst;
  logic        host_we;
  logic [2:0]  host_addr;
  logic [15:0] host_data;
  logic        host_choice;
  logic [3:0]  host_count;
  logic        host_go;
  logic        host_abort;
  logic        pluseinter;
  logic [15:0] plusedatain;
  logic        pluseload;
  logic        pluseloadchoice;
  logic        plusestart;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic        err_wr_busy;

  int          total = 0;
  int          bad   = 0;
  int          ecount = 0;
  exp_t        q[$];
  logic [16:0] model [DEPTH];

  pluse_param_loader #(
    .DEPTH   (DEPTH),
    .LOAD_W  (L),
    .TIMEOUT (TMO)
  ) dut (
    .clk_sys         (clk),
    .pluserst        (pluserst),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_data       (host_data),
    .host_choice     (host_choice),
    .host_count      (host_count),
    .host_go         (host_go),
    .host_abort      (host_abort),
    .pluseinter      (pluseinter),
    .plusedatain     (plusedatain),
    .pluseload       (pluseload),
    .pluseloadchoice (pluseloadchoice),
    .plusestart      (plusestart),
    .busy            (busy),
    .done            (done),
    .err_timeout     (err_timeout),
    .err_wr_busy     (err_wr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecount <= ecount + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents a load strobe,
  // a start pulse, or the end of a run (busy falling).
  exp_t        cur;
  exp_t        me;
  int          run_len = 0;
  logic        p_load  = 1'b0;
  logic        p_busy  = 1'b0;
  logic [16:0] p_word  = '0;

  always @(negedge clk) begin
    if (pluseload && !p_load) begin
      chk("load_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        me  = q.pop_front();
        cur = me;
        chk("load_kind", me.kind, K_LOAD);
        chk("load_cycle", ecount, me.cyc);
        chk("load_word", {pluseloadchoice, plusedatain}, me.word);
        chk("setup_word", p_word, me.word);
      end
      run_len = 1;
    end else if (pluseload) begin
      run_len++;
    end
    if (!pluseload && p_load) begin
      chk("strobe_len", run_len, cur.len);
      chk("hold_word", {pluseloadchoice, plusedatain}, cur.hold);
    end
    if (plusestart) begin
      chk("start_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        me = q.pop_front();
        chk("start_kind", me.kind, K_START);
        chk("start_cycle", ecount, me.cyc);
        chk("start_data", {pluseloadchoice, plusedatain}, 0);
      end
    end
    if (p_busy && !busy) begin
      chk("end_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        me = q.pop_front();
        chk("end_kind", me.kind, K_END);
        chk("end_cycle", ecount, me.cyc);
        chk("end_flags", {done, err_timeout, err_wr_busy}, me.flags);
        chk("end_outs_zero", {pluseload, plusestart, pluseloadchoice, plusedatain}, 0);
      end
    end
    p_load = pluseload;
    p_busy = busy;
    p_word = {pluseloadchoice, plusedatain};
  end

  task automatic wr(input int a, input logic [16:0] w);
    @(negedge clk);
    host_we   = 1'b1;
    host_addr = 3'(a);
    {host_choice, host_data} = w;
    model[a]  = w;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) wr(i, 17'($urandom));
  endtask

  // mode M_INT: pluseinter rises in cycle 'at'; M_TO: no edge; M_ABT/M_RST:
  // abort / reset asserted in cycle 'at'. Cycle 0 is the go cycle.
  task automatic run(input int nreq, input int mode, input int at, input int wb_k,
                     input bit inter_hi, input bit same_wr);
    int          n, go_e, w0, endk, ks;
    logic [2:0]  fl;
    logic [16:0] nw;
    exp_t        e;
    n  = (nreq > DEPTH) ? DEPTH : nreq;
    w0 = 2 + n * P;
    case (mode)
      M_INT:   begin endk = at + 1;   fl = {1'b1, 1'b0, 1'(wb_k > 0)}; end
      M_TO:    begin endk = w0 + TMO; fl = {1'b0, 1'b1, 1'(wb_k > 0)}; end
      default: begin endk = at + 1;   fl = 3'b000; end
    endcase
    @(negedge clk);
    go_e       = ecount + 1;
    pluseinter = inter_hi;
    host_go    = 1'b1;
    host_count = 4'(nreq);
    if (same_wr) begin
      nw        = 17'($urandom);
      host_we   = 1'b1;
      host_addr = 3'd0;
      {host_choice, host_data} = nw;
      model[0]  = nw;
    end
    for (int i = 0; i < n; i++) begin
      ks = 2 + i * P;
      if (mode >= M_ABT && ks > at) break;
      e.kind  = K_LOAD;
      e.cyc   = go_e + ks - 1;
      e.word  = model[i];
      e.len   = (mode >= M_ABT && at + 1 < ks + L) ? at + 1 - ks : L;
      e.hold  = (mode < M_ABT || at >= ks + L) ? model[i] : 17'd0;
      e.flags = '0;
      q.push_back(e);
    end
    if (mode < M_ABT || 1 + n * P <= at) begin
      e.kind = K_START;
      e.cyc  = go_e + n * P;
      q.push_back(e);
    end
    e.kind  = K_END;
    e.cyc   = go_e + endk - 1;
    e.flags = fl;
    q.push_back(e);
    for (int k = 1; k <= endk + 1; k++) begin
      @(negedge clk);
      host_go    = 1'b0;
      host_we    = 1'b0;
      host_abort = 1'b0;
      pluserst   = 1'b1;
      if (mode == M_INT && k == at) pluseinter = 1'b1;
      if (k == wb_k) begin
        host_we     = 1'b1;
        host_go     = 1'b1;
        host_addr   = 3'd2;
        host_data   = 16'($urandom);
        host_choice = 1'($urandom);
      end
      if (mode == M_ABT && k == at) host_abort = 1'b1;
      if (mode == M_RST && k == at) pluserst = 1'b0;
    end
    if (mode == M_RST) fill_all();
  endtask

  initial begin
    int n, mode, at, wb;
    pluserst    = 1'b0;
    host_we     = 1'b0;
    host_addr   = '0;
    host_data   = '0;
    host_choice = 1'b0;
    host_count  = '0;
    host_go     = 1'b0;
    host_abort  = 1'b0;
    pluseinter  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {plusedatain, pluseload, pluseloadchoice, plusestart,
                       busy, done, err_timeout, err_wr_busy}, 0);
    pluserst = 1'b1;

    wr(0, {1'b0, 16'h1234});
    wr(1, {1'b1, 16'hABCD});
    wr(2, {1'b0, 16'h0F0F});
    for (int i = 3; i < DEPTH; i++) wr(i, 17'($urandom));

    run(3, M_INT, 20, 0, 1'b0, 1'b0);             // three-word load
    run(0, M_INT, 4, 0, 1'b0, 1'b0);              // count 0
    run(12, M_INT, 2 + 8 * P + 3, 0, 1'b0, 1'b0); // clamp to 8
    run(0, M_TO, 0, 0, 1'b1, 1'b0);               // timeout, level held high
    run(3, M_ABT, 2 + P, 0, 1'b0, 1'b0);          // abort in STROBE of word 1
    run(3, M_RST, 2 + P, 0, 1'b0, 1'b0);          // reset in STROBE of word 1
    run(4, M_INT, 2 + 4 * P + 2, 3, 1'b0, 1'b0);  // write while busy
    run(4, M_INT, 2 + 4 * P + 1, 0, 1'b0, 1'b0);  // entry 2 unchanged
    run(2, M_INT, 2 + 2 * P, 0, 1'b0, 1'b1);      // go + write same cycle
    run(1, M_INT, 2 + P + TMO - 1, 0, 1'b0, 1'b0);// edge and timeout together

    @(negedge clk);
    host_go    = 1'b1;
    host_abort = 1'b1;
    host_count = 4'd3;
    @(negedge clk);
    host_go    = 1'b0;
    host_abort = 1'b0;
    repeat (4) begin
      chk("abort_go_busy", busy, 0);
      @(negedge clk);
    end
    chk("abort_go_done_kept", done, 1);

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(1, 0) == 1) wr($urandom_range(DEPTH - 1, 0), 17'($urandom));
      n    = $urandom_range(15, 0);
      mode = $urandom_range(3, 0);
      wb   = 0;
      case (mode)
        M_INT: begin
          at = $urandom_range(2 + ((n > DEPTH) ? DEPTH : n) * P + TMO - 1,
                              2 + ((n > DEPTH) ? DEPTH : n) * P);
          if ($urandom_range(1, 0) == 1) wb = $urandom_range(1 + ((n > DEPTH) ? DEPTH : n) * P, 1);
          run(n, M_INT, at, wb, 1'b0, 1'($urandom));
        end
        M_TO: begin
          if ($urandom_range(1, 0) == 1) wb = $urandom_range(1 + ((n > DEPTH) ? DEPTH : n) * P, 1);
          run(n, M_TO, 0, wb, 1'($urandom), 1'($urandom));
        end
        default: begin
          at = $urandom_range(7 + ((n > DEPTH) ? DEPTH : n) * P, 1);
          run(n, mode, at, 0, 1'b0, 1'b0);
        end
      endcase
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
